// File: rtl/sb_config_loader.sv
// sb_config_loader
//   Configuration controller for a daisy chain of switch-box tiles, each tile
//   holding a WORD_W-bit config shift register. Words arrive on a valid/ready
//   handshake and are serialized LSB-first onto prog_in while prog_en is high.
//   In verify mode the host resends the same stream and each bit returning on
//   chain_out is compared with the bit being sent.
//
// Ports
//   prog_clk      config clock, all state on posedge
//   rst           asynchronous, active-low reset
//   start         one-cycle pass request, ignored while busy
//   mode          sampled with start: 0 = load, 1 = verify
//   abort         terminate the current pass, no done pulse
//   cfg_data      config word
//   cfg_valid     cfg_data valid
//   cfg_ready     block accepts a word this cycle
//   prog_in       serial bit to the first tile
//   prog_en       chain shift enable
//   chain_out     prog_out of the last tile
//   busy          pass in progress
//   done          one-cycle pulse at pass completion
//   error         sticky verify-mismatch flag, cleared by the next start
//   mismatch_cnt  saturating count of mismatched bits in the last verify pass
module sb_config_loader #(
   parameter int unsigned NUM_TILES = 4,
   parameter int unsigned WORD_W    = 32
) (
   input  logic              prog_clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic              abort,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              prog_in,
   output logic              prog_en,
   input  logic              chain_out,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [15:0]       mismatch_cnt
);

   localparam int unsigned BCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int unsigned WCW = $clog2(NUM_TILES + 1);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_W - 1);
   localparam logic [WCW-1:0] WORD_LAST = WCW'(NUM_TILES - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_WORD,
      SHIFT,
      FINISH
   } state_t;

   state_t             state_q, state_d;
   logic               mode_q, mode_d;
   logic [WORD_W-1:0]  shift_buf_q, shift_buf_d;
   logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [WCW-1:0]     word_cnt_q, word_cnt_d;
   logic               cfg_ready_q, cfg_ready_d;
   logic               prog_in_q, prog_in_d;
   logic               prog_en_q, prog_en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic [15:0]        mm_q, mm_d;

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      shift_buf_d = shift_buf_q;
      bit_cnt_d   = bit_cnt_q;
      word_cnt_d  = word_cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = error_q;
      mm_d        = mm_q;
      // The serial outputs trail the SHIFT state by one register stage, so
      // the bit selected while in SHIFT appears on prog_in the next cycle.
      prog_en_d   = (state_q == SHIFT);
      prog_in_d   = (state_q == SHIFT) ? shift_buf_q[bit_cnt_q] : 1'b0;

      // Compare the bit currently on the chain input with the returning tail
      // bit; this includes the final bit, which is compared on the FINISH edge.
      if (mode_q && prog_en_q && (chain_out != prog_in_q) && (mm_q != '1)) begin
         mm_d = mm_q + 16'd1;
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = WAIT_WORD;
               mode_d     = mode;
               mm_d       = '0;
               error_d    = 1'b0;
               busy_d     = 1'b1;
               word_cnt_d = '0;
            end
         end
         WAIT_WORD: begin
            if (cfg_valid && cfg_ready_q) begin
               shift_buf_d = cfg_data;
               bit_cnt_d   = '0;
               state_d     = SHIFT;
            end
         end
         SHIFT: begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
               word_cnt_d = word_cnt_q + 1'b1;
               state_d    = (word_cnt_q == WORD_LAST) ? FINISH : WAIT_WORD;
            end
         end
         FINISH: begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            error_d = (mm_d != '0);
         end
         default: state_d = IDLE;
      endcase

      // abort overrides everything, including a start in IDLE, and leaves the
      // verify results of the interrupted pass untouched.
      if (abort) begin
         state_d   = IDLE;
         mode_d    = mode_q;
         prog_en_d = 1'b0;
         prog_in_d = 1'b0;
         busy_d    = 1'b0;
         done_d    = 1'b0;
         error_d   = error_q;
         mm_d      = mm_q;
      end

      cfg_ready_d = (state_d == WAIT_WORD);
   end

   always_ff @(posedge prog_clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         shift_buf_q <= '0;
         bit_cnt_q   <= '0;
         word_cnt_q  <= '0;
         cfg_ready_q <= 1'b0;
         prog_in_q   <= 1'b0;
         prog_en_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         mm_q        <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         shift_buf_q <= shift_buf_d;
         bit_cnt_q   <= bit_cnt_d;
         word_cnt_q  <= word_cnt_d;
         cfg_ready_q <= cfg_ready_d;
         prog_in_q   <= prog_in_d;
         prog_en_q   <= prog_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         mm_q        <= mm_d;
      end
   end

   assign cfg_ready    = cfg_ready_q;
   assign prog_in      = prog_in_q;
   assign prog_en      = prog_en_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign mismatch_cnt = mm_q;

endmodule

// File: tb/tb_sb_config_loader.sv
// tb_sb_config_loader
//   Drives sb_config_loader with directed and randomized passes, models the
//   tile chain as a plain shift register, and checks pass results against a
//   reference that tracks tile contents per word.
module tb_sb_config_loader;

   localparam int NT = 4;
   localparam int CL = 32 * NT;

   logic        prog_clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] cfg_data = '0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic        prog_in;
   logic        prog_en;
   logic        chain_out;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] mismatch_cnt;

   always #5 prog_clk = ~prog_clk;

   sb_config_loader #(.NUM_TILES(NT), .WORD_W(32)) dut (
      .prog_clk     (prog_clk),
      .rst          (rst),
      .start        (start),
      .mode         (mode),
      .abort        (abort),
      .cfg_data     (cfg_data),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .prog_in      (prog_in),
      .prog_en      (prog_en),
      .chain_out    (chain_out),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .mismatch_cnt (mismatch_cnt)
   );

   // Tile chain: tile 0 occupies the top word, each tile shifts toward bit 0.
   logic [CL-1:0] chain;
   bit            tie_one = 1'b0;

   always @(posedge prog_clk or negedge rst) begin
      if (!rst) chain <= '0;
      else if (prog_en) chain <= {prog_in, chain[CL-1:1]};
   end
   assign chain_out = tie_one ? 1'b1 : chain[0];

   function automatic logic [31:0] tile(input int t);
      return chain[CL-1-32*t -: 32];
   endfunction

   // Activity monitor, sampled on the falling edge.
   int cyc = 0, en_cnt = 0, runs = 0, done_cnt = 0, done_cyc = 0, gap = 0;
   bit prev_en = 1'b0;
   int gaps[$];

   always @(negedge prog_clk) begin
      cyc++;
      if (prog_en) begin
         if (!prev_en) begin
            gaps.push_back(gap);
            runs++;
         end
         en_cnt++;
         gap = 0;
      end else begin
         gap++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      prev_en = prog_en;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [31:0] words[NT];
   int          stall[NT];
   logic [31:0] ref_tile[NT];

   task automatic tick;
      @(negedge prog_clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_prog_en"}, 32'(prog_en), 32'd0);
      check_eq({tag, "_prog_in"}, 32'(prog_in), 32'd0);
      check_eq({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_done"}, 32'(done), 32'd0);
      check_eq({tag, "_error"}, 32'(error), 32'd0);
      check_eq({tag, "_mm"}, 32'(mismatch_cnt), 32'd0);
   endtask

   // One pass of NT words. abort_word >= 0 aborts at bit abort_bit of that word.
   task automatic run_pass(input logic m, input int abort_word, input int abort_bit,
                           input bit poke_start);
      int  d0, e0, r0, g0, s_cyc, n, exp_mm;
      bit  no_stall;
      d0 = done_cnt; e0 = en_cnt; r0 = runs; g0 = gaps.size();
      no_stall = 1'b1;
      start = 1'b1; mode = m; s_cyc = cyc;
      tick;
      start = 1'b0; mode = 1'b0;
      check_eq("busy_after_start", 32'(busy), 32'd1);
      for (int k = 0; k < NT; k++) begin
         cfg_data = words[k];
         cfg_valid = (stall[k] == 0);
         n = 0;
         while (!cfg_ready && n < 100) begin tick; n++; end
         if (!cfg_ready) begin
            check_eq("ready_timeout", 32'(cfg_ready), 32'd1);
            cfg_valid = 1'b0;
            return;
         end
         if (stall[k] != 0) begin
            no_stall = 1'b0;
            repeat (stall[k]) tick;
            check_eq("ready_held_in_stall", 32'(cfg_ready), 32'd1);
            check_eq("en_low_in_stall", 32'(prog_en), 32'd0);
         end
         cfg_valid = 1'b1;
         tick;
         if (poke_start && k == 1) begin
            start = 1'b1; mode = ~m;
            tick;
            start = 1'b0; mode = 1'b0;
         end
         if (k == abort_word) begin
            repeat (abort_bit) tick;
            abort = 1'b1; cfg_valid = 1'b1;
            tick;
            abort = 1'b0; cfg_valid = 1'b0;
            check_eq("abort_prog_en", 32'(prog_en), 32'd0);
            check_eq("abort_busy", 32'(busy), 32'd0);
            check_eq("abort_cfg_ready", 32'(cfg_ready), 32'd0);
            repeat (6) tick;
            check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);
            check_eq("abort_en_cycles", 32'(en_cnt - e0), 32'(32 * k + abort_bit));
            return;
         end
      end
      cfg_valid = 1'b0;
      n = 0;
      while (done_cnt == d0 && n < 300) begin tick; n++; end
      check_eq("done_seen", 32'(done_cnt - d0), 32'd1);

      exp_mm = 0;
      for (int k = 0; k < NT; k++)
         exp_mm += $countones(words[k] ^ (tie_one ? 32'hFFFF_FFFF : ref_tile[NT-1-k]));
      if (m == 1'b0) exp_mm = 0;
      if (exp_mm > 16'hFFFF) exp_mm = 16'hFFFF;
      check_eq("mismatch_cnt", 32'(mismatch_cnt), 32'(exp_mm));
      check_eq("error", 32'(error), 32'(exp_mm != 0));

      for (int k = 0; k < NT; k++) ref_tile[NT-1-k] = words[k];
      for (int t = 0; t < NT; t++) check_eq($sformatf("tile%0d", t), tile(t), ref_tile[t]);

      check_eq("en_cycles", 32'(en_cnt - e0), 32'(CL));
      check_eq("en_runs", 32'(runs - r0), 32'(NT));
      for (int k = 1; k < NT; k++)
         if (g0 + k < gaps.size())
            check_eq($sformatf("bubble%0d", k), 32'(gaps[g0+k]), 32'(1 + stall[k]));
      if (no_stall && !poke_start)
         check_eq("done_latency", 32'(done_cyc - s_cyc), 32'(CL + NT + 2));
      tick;
      check_eq("done_one_cycle", 32'(done), 32'd0);
      check_eq("busy_after_done", 32'(busy), 32'd0);
   endtask

   task automatic clear_stall;
      for (int k = 0; k < NT; k++) stall[k] = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int t = 0; t < NT; t++) ref_tile[t] = '0;
      clear_stall();
      repeat (3) tick;
      check_idle_outputs("reset");
      rst = 1'b1;
      tick;

      // Directed load then clean verify.
      words[0] = 32'h1111_1111; words[1] = 32'h2222_2222;
      words[2] = 32'h3333_3333; words[3] = 32'h4444_4444;
      run_pass(1'b0, -1, 0, 1'b0);
      run_pass(1'b1, -1, 0, 1'b0);
      // Verify with a single flipped bit.
      words[2] = 32'h3333_3337;
      run_pass(1'b1, -1, 0, 1'b0);

      // Stall of 10 cycles before the second word.
      for (int k = 0; k < NT; k++) words[k] = $urandom;
      stall[1] = 10;
      run_pass(1'b0, -1, 0, 1'b0);
      clear_stall();

      // Abort at bit 15 of the second word, then a full reload.
      for (int k = 0; k < NT; k++) words[k] = $urandom;
      run_pass(1'b0, 1, 15, 1'b0);
      for (int k = 0; k < NT; k++) words[k] = $urandom;
      run_pass(1'b0, -1, 0, 1'b0);

      // Asynchronous reset mid-shift of a failing verify pass.
      tie_one = 1'b1;
      start = 1'b1; mode = 1'b1;
      tick;
      start = 1'b0; mode = 1'b0;
      cfg_data = '0; cfg_valid = 1'b1;
      repeat (20) tick;
      check_eq("mm_before_reset", 32'(mismatch_cnt != 0), 32'd1);
      rst = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      cfg_valid = 1'b0; tie_one = 1'b0;
      for (int t = 0; t < NT; t++) ref_tile[t] = '0;
      tick;
      rst = 1'b1;
      tick;

      // cfg_valid in IDLE, start together with abort in IDLE.
      begin
         int e0;
         e0 = en_cnt;
         cfg_valid = 1'b1; cfg_data = 32'hDEAD_BEEF;
         repeat (5) tick;
         check_eq("idle_valid_ready", 32'(cfg_ready), 32'd0);
         check_eq("idle_valid_en", 32'(en_cnt - e0), 32'd0);
         cfg_valid = 1'b0;
         start = 1'b1; abort = 1'b1;
         tick;
         start = 1'b0; abort = 1'b0;
         check_eq("start_abort_busy", 32'(busy), 32'd0);
         check_eq("start_abort_ready", 32'(cfg_ready), 32'd0);
      end

      // start pulsed mid-pass with the opposite mode must not restart or relatch.
      for (int k = 0; k < NT; k++) words[k] = $urandom;
      run_pass(1'b0, -1, 0, 1'b1);

      // All-zero verify against a tail stuck at 1.
      for (int k = 0; k < NT; k++) words[k] = '0;
      run_pass(1'b0, -1, 0, 1'b0);
      tie_one = 1'b1;
      run_pass(1'b1, -1, 0, 1'b0);
      tie_one = 1'b0;

      // Randomized passes: random loads, or verifies of the current contents
      // with occasional single-bit corruptions, under random stalls.
      for (int p = 0; p < 8; p++) begin
         logic m;
         m = 1'($urandom_range(0, 1));
         for (int k = 0; k < NT; k++) begin
            stall[k] = (k == 0) ? 0 : $urandom_range(0, 3);
            if (m) begin
               words[k] = ref_tile[NT-1-k];
               if ($urandom_range(0, 2) == 0) words[k] ^= 32'd1 << $urandom_range(0, 31);
            end else begin
               words[k] = $urandom;
            end
         end
         run_pass(m, -1, 0, 1'b0);
      end
      clear_stall();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
